apb_rr_master: RTL and testbench

APB requester arbiter and master sequencer sitting in front of the 32-word APB RAM slave. It accepts simple valid/ready transactions from `NREQ` local requesters and picks one per transfer round-robin. It drives the full APB setup/access handshake, returns read data and error status to the granted requester, and aborts transfers whose slave never raises `pready`.

---
 rtl/apb_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/apb_rr_master.sv | 123 ++++++++++++
 tb/tb_apb_rr_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types for the APB requester/master path: FSM states, bus widths and
// the response record returned to a requester.
package apb_ctrl_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_mst_state_t;

    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              err;
    } apb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starting just after the last
// accepted winner. Requester 0 leads after reset.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         pclk,
    input  logic         presetn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    // Pointer parked on N-1 so the first scan after reset starts at 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            last <= IW'(N - 1);
        else if (advance && found)
            last <= win;
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sequencer fronted by a round-robin arbiter over NREQ requesters;
// drives SETUP/ACCESS, returns data/error and aborts on pready timeout.
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*APB_AW-1:0] req_addr,
    input  logic [NREQ*APB_DW-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [APB_AW-1:0]      paddr,
    output logic [APB_DW-1:0]      pwdata,
    input  logic [APB_DW-1:0]      prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int CW = $clog2(TIMEOUT);

    apb_mst_state_t    state;
    apb_rsp_t          rsp_q;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   gnt_q;
    logic [CW-1:0]     wcnt;
    logic              accept;
    logic              sel_write;
    logic [APB_AW-1:0] sel_addr;
    logic [APB_DW-1:0] sel_wdata;

    assign accept    = (state == IDLE) && (|req_valid);
    assign req_ready = (state == IDLE) ? grant : '0;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    rr_arbiter #(.N(NREQ)) u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[APB_AW*i +: APB_AW];
                sel_wdata = req_wdata[APB_DW*i +: APB_DW];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            gnt_q     <= '0;
            wcnt      <= '0;
            rsp_valid <= '0;
            rsp_q     <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= SETUP;
                        psel   <= 1'b1;
                        pwrite <= sel_write;
                        paddr  <= sel_addr;
                        pwdata <= sel_wdata;
                        gnt_q  <= grant;
                        wcnt   <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // pready is checked first so a response in the last
                    // allowed cycle completes normally.
                    if (pready) begin
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= gnt_q;
                        rsp_q.rdata <= pwrite ? '0 : prdata;
                        rsp_q.err   <= pslverr;
                    end else if (wcnt == CW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= gnt_q;
                        rsp_q.rdata <= '0;
                        rsp_q.err   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master (NREQ=2, TIMEOUT=4) with a 32-word APB RAM
// model plus stuck and late-pready stub modes for the timeout cases.
module tb_apb_rr_master;

    logic        pclk;
    logic        presetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vecs = 0;
    int errs = 0;

    // 0 = RAM, 1 = pready stuck low, 2 = pready in 4th ACCESS cycle
    int          mode = 0;
    logic [31:0] mem [32];
    logic        ram_rdy = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        ram_err = 1'b0;
    int          acc_n = 0;
    logic [31:0] snap;

    apb_rr_master #(.NREQ(2), .TIMEOUT(4)) u_dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        ram_rdy <= (mode == 0) && psel && penable && !ram_rdy;
        if (psel && penable && !ram_rdy) begin
            ram_rdata <= (paddr < 32) ? mem[paddr[4:0]] : 32'h0;
            ram_err   <= (paddr >= 32);
        end
        if (mode == 0 && psel && penable && ram_rdy && pwrite && paddr < 32)
            mem[paddr[4:0]] <= pwdata;
        acc_n <= (psel && penable) ? acc_n + 1 : 0;
    end

    assign pready  = (mode == 0) ? ram_rdy : ((mode == 2) && psel && penable && acc_n == 3);
    assign prdata  = (mode == 0) ? ram_rdata : 32'hBAD0BAD0;
    assign pslverr = (mode == 0) ? ram_err : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
    endtask

    function automatic logic [31:0] mem_sum();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) s = s + (mem[i] ^ 32'(i * 32'h01010101));
        return s;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_psel"}, psel, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        logic [1:0] exp;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 + 32'(i);
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        cyc();
        cyc();
        chk_reset_state("rst0");
        presetn = 1'b1;

        // 1: single write then read
        cyc();
        req_valid = 2'b01;
        set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
        #1;
        chk("t1_ready_T", req_ready, 2'b01);
        chk("t1_psel_T", psel, 0);
        cyc();
        req_valid = 2'b00;
        chk("t1_psel_T1", psel, 1);
        chk("t1_penable_T1", penable, 0);
        chk("t1_paddr_T1", paddr, 32'd5);
        cyc();
        chk("t1_penable_T2", penable, 1);
        chk("t1_pwdata_T2", pwdata, 32'hDEADBEEF);
        cyc();
        chk("t1_rsp_valid_T3", rsp_valid, 0);
        cyc();
        chk("t1_rsp_valid_T4", rsp_valid, 2'b01);
        chk("t1_rsp_err_T4", rsp_err, 0);
        chk("t1_psel_T4", psel, 0);
        req_valid = 2'b01;
        set_req(0, 1'b0, 32'd5, 32'h0);
        #1;
        chk("t1_rd_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        cyc();
        chk("t1_rd_valid", rsp_valid, 2'b01);
        chk("t1_rd_data", rsp_rdata, 32'hDEADBEEF);
        chk("t1_rd_err", rsp_err, 0);

        // 2: reset, then fairness with both requesters held
        cyc();
        presetn = 1'b0;
        #1;
        chk_reset_state("rst1");
        cyc();
        presetn = 1'b1;
        cyc();
        set_req(0, 1'b1, 32'd1, 32'h11111111);
        set_req(1, 1'b1, 32'd2, 32'h22222222);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("t2_ready", req_ready, exp);
            chk("t2_psel_idle", psel, 0);
            repeat (4) cyc();
            chk("t2_rsp_valid", rsp_valid, exp);
        end
        req_valid = 2'b00;
        chk("t2_mem1", mem[1], 32'h11111111);
        chk("t2_mem2", mem[2], 32'h22222222);

        // 3: out-of-range read and write by requester 1
        snap = mem_sum();
        cyc();
        set_req(1, 1'b0, 32'd40, 32'h0);
        req_valid = 2'b10;
        #1;
        chk("t3_ready", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        chk("t3_rsp_valid", rsp_valid, 2'b10);
        chk("t3_rsp_err", rsp_err, 1);
        chk("t3_rsp_rdata", rsp_rdata, 0);
        set_req(1, 1'b1, 32'd37, 32'hFFFF0000);
        req_valid = 2'b10;
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        chk("t3_wr_valid", rsp_valid, 2'b10);
        chk("t3_wr_err", rsp_err, 1);
        chk("t3_mem_sum", mem_sum(), snap);
        chk("t3_mem5", mem[5], 32'hDEADBEEF);

        // 4a: timeout with pready stuck low
        cyc();
        mode = 1;
        set_req(0, 1'b0, 32'd3, 32'h0);
        req_valid = 2'b01;
        #1;
        chk("t4_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4_access", {psel, penable}, 2'b11);
            chk("t4_no_rsp", rsp_valid, 0);
        end
        cyc();
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        chk("t4_psel_drop", psel, 0);

        // 4b: pready arrives in the 4th ACCESS cycle
        mode = 2;
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        repeat (4) cyc();
        chk("t4b_access4", penable, 1);
        cyc();
        chk("t4b_rsp_valid", rsp_valid, 2'b01);
        chk("t4b_rsp_err", rsp_err, 0);
        chk("t4b_rsp_rdata", rsp_rdata, 32'hBAD0BAD0);

        // 5: reset during ACCESS, then both request
        mode = 1;
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        chk("t5_in_access", penable, 1);
        presetn = 1'b0;
        #1;
        chk("t5_psel_rst", psel, 0);
        chk("t5_penable_rst", penable, 0);
        cyc();
        presetn = 1'b1;
        mode = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t5_no_rsp", rsp_valid, 0);
        end
        set_req(0, 1'b0, 32'd5, 32'h0);
        set_req(1, 1'b0, 32'd1, 32'h0);
        req_valid = 2'b11;
        #1;
        chk("t5_first_grant", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        repeat (3) cyc();
        chk("t5_rsp_valid", rsp_valid, 2'b01);
        chk("t5_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
